cpri_tx_gen: RTL and testbench

CPRI_TX_GEN -- requirements
Module: cpri_tx_gen

---
 rtl/cpri_pkg.sv | 22 ++
 rtl/cpri_tx_gen.sv | 176 +++++++++++++++++
 tb/tb_cpri_tx_gen.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpri_pkg.sv
// CPRI framing constants, FSM state type and header helper
// shared by the transmit and receive sides of the CPRI chunk path.
package cpri_pkg;

    localparam int CPRI_HDR_WORDS     = 3;
    localparam int CPRI_PAYLOAD_WORDS = 96;
    localparam int CPRI_LAST_ADDR     = 98;

    localparam logic [15:0] CPRI_SYNC = 16'hBCBC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD
    } cpri_state_e;

    // Header word 0: sync, reserved, sequence number, payload length.
    function automatic logic [63:0] cpri_hdr0(input logic [15:0] seq);
        return {CPRI_SYNC, 16'h0000, seq, 16'(CPRI_PAYLOAD_WORDS)};
    endfunction

endpackage

// File: rtl/cpri_tx_gen.sv
// CPRI chunk generator: frames 96 upstream IQ words behind a
// 3-word header and writes the 99-word chunk into the CPRI buffer.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   i_tx_enable       permits a new chunk to start
//   i_iq_*/o_iq_*     upstream IQ stream (valid/ready, data, last)
//   i_hdr_info        header word 1, captured at chunk start
//   i_cpri_tready     downstream buffer has room for a word
//   o_cpri_w*         registered buffer write port (en/addr/data/last)
//   o_seq_num         chunk sequence number
//   o_len_err         one-cycle pulse on upstream tlast mismatch
module cpri_tx_gen
    import cpri_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tx_enable,
    input  logic                  i_iq_tvalid,
    output logic                  o_iq_tready,
    input  logic [DATA_WIDTH-1:0] i_iq_tdata,
    input  logic                  i_iq_tlast,
    input  logic [63:0]           i_hdr_info,
    input  logic                  i_cpri_tready,
    output logic                  o_cpri_wen,
    output logic [ADDR_WIDTH-1:0] o_cpri_waddr,
    output logic [DATA_WIDTH-1:0] o_cpri_wdata,
    output logic                  o_cpri_wlast,
    output logic [15:0]           o_seq_num,
    output logic                  o_len_err
);

    localparam logic [6:0] PAY_LAST = 7'(CPRI_PAYLOAD_WORDS - 1);
    localparam logic [1:0] HDR_LAST = 2'(CPRI_HDR_WORDS - 1);

    cpri_state_e state_q, state_d;

    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [6:0]  pay_idx_q, pay_idx_d;
    logic [15:0] seq_q, seq_d;
    logic [63:0] hdr_info_q;
    logic        hdr_latch;

    logic                  wen_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  wlast_d;
    logic                  len_err_d;

    logic        start;
    logic        accept;
    logic        last_pay;
    logic [1:0]  hdr_sel;
    logic [63:0] hdr_word;

    assign start    = i_tx_enable && i_iq_tvalid;
    assign o_iq_tready = (state_q == ST_PAYLOAD) && i_cpri_tready;
    assign accept   = o_iq_tready && i_iq_tvalid;
    assign last_pay = (pay_idx_q == PAY_LAST);
    assign o_seq_num = seq_q;

    // In IDLE the only header word that can go out is word 0.
    assign hdr_sel = (state_q == ST_IDLE) ? 2'd0 : hdr_idx_q;

    always_comb begin
        hdr_word = 64'h0;
        unique case (hdr_sel)
            2'd0:    hdr_word = cpri_hdr0(seq_q);
            2'd1:    hdr_word = hdr_info_q;
            default: hdr_word = 64'h0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        pay_idx_d = pay_idx_q;
        seq_d     = seq_q;
        hdr_latch = 1'b0;
        wen_d     = 1'b0;
        waddr_d   = o_cpri_waddr;
        wdata_d   = o_cpri_wdata;
        wlast_d   = 1'b0;
        len_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_HDR;
                    hdr_latch = 1'b1;
                    pay_idx_d = 7'd0;
                    hdr_idx_d = 2'd0;
                    // Word 0 goes out on the start edge so that a
                    // following chunk lands right after wlast.
                    if (i_cpri_tready) begin
                        wen_d     = 1'b1;
                        waddr_d   = '0;
                        wdata_d   = DATA_WIDTH'(hdr_word);
                        hdr_idx_d = 2'd1;
                    end
                end
            end

            ST_HDR: begin
                if (i_cpri_tready) begin
                    wen_d   = 1'b1;
                    waddr_d = ADDR_WIDTH'(hdr_idx_q);
                    wdata_d = DATA_WIDTH'(hdr_word);
                    if (hdr_idx_q == HDR_LAST) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
                    wen_d   = 1'b1;
                    waddr_d = ADDR_WIDTH'(CPRI_HDR_WORDS)
                            + ADDR_WIDTH'(pay_idx_q);
                    wdata_d = i_iq_tdata;
                    wlast_d = last_pay;
                    // tlast is advisory: framing is fixed-length.
                    len_err_d = last_pay ? !i_iq_tlast : i_iq_tlast;
                    if (last_pay) begin
                        state_d = ST_IDLE;
                        seq_d   = seq_q + 16'd1;
                    end else begin
                        pay_idx_d = pay_idx_q + 7'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_idx_q  <= 2'd0;
            pay_idx_q  <= 7'd0;
            seq_q      <= 16'd0;
            hdr_info_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            pay_idx_q <= pay_idx_d;
            seq_q     <= seq_d;
            if (hdr_latch) begin
                hdr_info_q <= i_hdr_info;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cpri_wen   <= 1'b0;
            o_cpri_waddr <= '0;
            o_cpri_wdata <= '0;
            o_cpri_wlast <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            o_cpri_wen   <= wen_d;
            o_cpri_waddr <= waddr_d;
            o_cpri_wdata <= wdata_d;
            o_cpri_wlast <= wlast_d;
            o_len_err    <= len_err_d;
        end
    end

endmodule

// File: tb/tb_cpri_tx_gen.sv
// Self-checking bench for cpri_tx_gen: expected chunk words are
// queued as stimulus starts and compared against captured writes.
module tb_cpri_tx_gen;

    typedef struct {
        logic [6:0]  addr;
        logic [63:0] data;
        logic        last;
        logic        err;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_enable;
    logic        iq_tvalid;
    logic        iq_tready;
    logic [63:0] iq_tdata;
    logic        iq_tlast;
    logic [63:0] hdr_info;
    logic        cpri_tready;
    logic        cpri_wen;
    logic [6:0]  cpri_waddr;
    logic [63:0] cpri_wdata;
    logic        cpri_wlast;
    logic [15:0] seq_num;
    logic        len_err;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int stray_err = 0;
    logic abort = 1'b0;

    wr_t exp_q[$];
    wr_t recv[$];

    cpri_tx_gen #(.DATA_WIDTH(64), .ADDR_WIDTH(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_tx_enable  (tx_enable),
        .i_iq_tvalid  (iq_tvalid),
        .o_iq_tready  (iq_tready),
        .i_iq_tdata   (iq_tdata),
        .i_iq_tlast   (iq_tlast),
        .i_hdr_info   (hdr_info),
        .i_cpri_tready(cpri_tready),
        .o_cpri_wen   (cpri_wen),
        .o_cpri_waddr (cpri_waddr),
        .o_cpri_wdata (cpri_wdata),
        .o_cpri_wlast (cpri_wlast),
        .o_seq_num    (seq_num),
        .o_len_err    (len_err)
    );

    always #5 clk = ~clk;

    // Capture every buffer write with the cycle it appeared in.
    always @(negedge clk) begin
        wr_t r;
        cyc_n = cyc_n + 1;
        if (cpri_wen) begin
            r.addr = cpri_waddr;
            r.data = cpri_wdata;
            r.last = cpri_wlast;
            r.err  = len_err;
            r.cyc  = cyc_n;
            recv.push_back(r);
        end else if (len_err) begin
            stray_err = stray_err + 1;
        end
    end

    task automatic push_chunk(input logic [15:0] seq,
                              input logic [63:0] hdr,
                              input logic [63:0] base,
                              input int lastpos);
        wr_t e;
        logic tl;
        e.cyc = 0;
        for (int i = 0; i < 99; i++) begin
            e.addr = 7'(i);
            e.last = (i == 98);
            e.err  = 1'b0;
            if (i == 0) begin
                e.data = {16'hBCBC, 16'h0000, seq, 16'd96};
            end else if (i == 1) begin
                e.data = hdr;
            end else if (i == 2) begin
                e.data = 64'h0;
            end else begin
                e.data = base + 64'(i - 3);
                tl = ((i - 3) == lastpos);
                e.err = ((i - 3) < 95) ? tl : !tl;
            end
            exp_q.push_back(e);
        end
    endtask

    // Present nchunks*96 words; word w carries base+w, tlast at lastpos.
    task automatic drive_words(input int nchunks, input int lastpos,
                               input logic [63:0] base);
        logic acc;
        int budget;
        for (int w = 0; w < nchunks * 96; w++) begin
            iq_tvalid = 1'b1;
            iq_tdata  = base + 64'(w);
            iq_tlast  = ((w % 96) == lastpos);
            budget = 0;
            acc = 1'b0;
            while (!acc && !abort) begin
                @(negedge clk);
                acc = iq_tready;
                @(posedge clk);
                #1;
                budget++;
                if (budget > 500) begin
                    checks++;
                    failures++;
                    $display("FAIL drive_timeout word=%0d got=none need=accept", w);
                    abort = 1'b1;
                end
            end
            if (abort) break;
        end
        iq_tvalid = 1'b0;
        iq_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && recv.size() < exp_q.size(); k++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        recv.delete();
        stray_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_enable = 1'b1;
        iq_tvalid = 1'b1;
        cpri_tready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cpri_wen !== 1'b0) begin
            failures++;
            $display("FAIL reset_wen got=%b need=0", cpri_wen);
        end
        checks++;
        if (cpri_waddr !== 7'd0) begin
            failures++;
            $display("FAIL reset_waddr got=%0d need=0", cpri_waddr);
        end
        checks++;
        if (cpri_wdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_wdata got=%h need=0", cpri_wdata);
        end
        checks++;
        if (cpri_wlast !== 1'b0 || len_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b need=00", cpri_wlast, len_err);
        end
        checks++;
        if (seq_num !== 16'd0) begin
            failures++;
            $display("FAIL reset_seq got=%0d need=0", seq_num);
        end
        checks++;
        if (iq_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_tready got=%b need=0", iq_tready);
        end
        tx_enable = 1'b0;
        iq_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_chunk();
        clear_sb();
        hdr_info = 64'h1122_3344_5566_7788;
        push_chunk(16'd0, hdr_info, 64'd0, 95);
        tx_enable = 1'b1;
        drive_words(1, 95, 64'd0);
        wait_drain();
        checks++;
        if (recv.size() !== 99) begin
            failures++;
            $display("FAIL single_count got=%0d need=99", recv.size());
        end
        for (int i = 0; i < recv.size() && i < exp_q.size(); i++) begin
            checks++;
            if (recv[i].addr !== exp_q[i].addr || recv[i].data !== exp_q[i].data
                || recv[i].last !== exp_q[i].last || recv[i].err !== exp_q[i].err) begin
                failures++;
                $display("FAIL single_word%0d got=%0d/%h/%b/%b need=%0d/%h/%b/%b", i,
                         recv[i].addr, recv[i].data, recv[i].last, recv[i].err,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].last, exp_q[i].err);
            end
        end
        checks++;
        if (stray_err !== 0) begin
            failures++;
            $display("FAIL single_stray_err got=%0d need=0", stray_err);
        end
        checks++;
        if (seq_num !== 16'd1) begin
            failures++;
            $display("FAIL single_seq got=%0d need=1", seq_num);
        end
    endtask

    task automatic stall_at(input logic [6:0] addr);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (cpri_wen && cpri_waddr == addr) break;
        end
        checks++;
        if (k >= 2000) begin
            failures++;
            $display("FAIL stall_wait addr=%0d got=none need=write", addr);
        end
        @(posedge clk);
        #1;
        cpri_tready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j > 0) begin
                checks++;
                if (cpri_wen !== 1'b0 || iq_tready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_write addr=%0d cyc=%0d got=%b%b need=00",
                             addr, j, cpri_wen, iq_tready);
                end
            end
        end
        @(posedge clk);
        #1;
        cpri_tready = 1'b1;
    endtask

    task automatic test_backpressure();
        clear_sb();
        hdr_info = 64'hA5A5_0000_FFFF_0001;
        push_chunk(16'd1, hdr_info, 64'h1000, 95);
        fork
            drive_words(1, 95, 64'h1000);
            begin
                stall_at(7'd1);
                stall_at(7'd50);
            end
        join
        wait_drain();
        checks++;
        if (recv.size() !== 99) begin
            failures++;
            $display("FAIL bp_count got=%0d need=99", recv.size());
        end
        for (int i = 0; i < recv.size() && i < exp_q.size(); i++) begin
            checks++;
            if (recv[i].addr !== exp_q[i].addr || recv[i].data !== exp_q[i].data
                || recv[i].last !== exp_q[i].last) begin
                failures++;
                $display("FAIL bp_word%0d got=%0d/%h/%b need=%0d/%h/%b", i,
                         recv[i].addr, recv[i].data, recv[i].last,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic run_b2b(input string name, input logic [15:0] seq0,
                           input logic [63:0] base);
        clear_sb();
        for (int c = 0; c < 3; c++) begin
            push_chunk(seq0 + 16'(c), hdr_info, base + 64'(c * 96), 95);
        end
        tx_enable = 1'b1;
        drive_words(3, 95, base);
        wait_drain();
        checks++;
        if (recv.size() !== 297) begin
            failures++;
            $display("FAIL %s_count got=%0d need=297", name, recv.size());
        end
        for (int i = 0; i < recv.size() && i < exp_q.size(); i++) begin
            checks++;
            if (recv[i].addr !== exp_q[i].addr || recv[i].data !== exp_q[i].data
                || recv[i].last !== exp_q[i].last) begin
                failures++;
                $display("FAIL %s_word%0d got=%0d/%h/%b need=%0d/%h/%b", name, i,
                         recv[i].addr, recv[i].data, recv[i].last,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
            if (i > 0 && exp_q[i].addr == 7'd0) begin
                checks++;
                if (recv[i].cyc !== recv[i-1].cyc + 1) begin
                    failures++;
                    $display("FAIL %s_gap%0d got=%0d need=%0d", name, i,
                             recv[i].cyc, recv[i-1].cyc + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        hdr_info = 64'hCAFE_F00D_0000_0003;
        run_b2b("b2b", 16'd0, 64'h2000);
        checks++;
        if (seq_num !== 16'd3) begin
            failures++;
            $display("FAIL b2b_seq got=%0d need=3", seq_num);
        end
    endtask

    task automatic test_len_err();
        int n;
        clear_sb();
        hdr_info = 64'h0;
        push_chunk(16'd3, hdr_info, 64'h3000, 40);
        drive_words(1, 40, 64'h3000);
        wait_drain();
        n = 0;
        for (int i = 0; i < recv.size() && i < exp_q.size(); i++) begin
            if (recv[i].err) n++;
            checks++;
            if (recv[i].addr !== exp_q[i].addr || recv[i].err !== exp_q[i].err
                || recv[i].last !== exp_q[i].last) begin
                failures++;
                $display("FAIL lenerr_word%0d got=%0d/%b/%b need=%0d/%b/%b", i,
                         recv[i].addr, recv[i].err, recv[i].last,
                         exp_q[i].addr, exp_q[i].err, exp_q[i].last);
            end
        end
        checks++;
        if (n !== 2 || recv.size() !== 99 || stray_err !== 0) begin
            failures++;
            $display("FAIL lenerr_total got=%0d/%0d/%0d need=2/99/0",
                     n, recv.size(), stray_err);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_sb();
        hdr_info = 64'h0BAD_0BAD_0BAD_0BAD;
        push_chunk(16'd4, hdr_info, 64'h4000, 95);
        fork
            drive_words(1, 95, 64'h4000);
            begin
                for (k = 0; k < 2000; k++) begin
                    @(negedge clk);
                    if (cpri_wen && cpri_waddr == 7'd60) break;
                end
                rst = 1'b1;
                abort = 1'b1;
                #1;
                checks++;
                if (cpri_wen !== 1'b0 || cpri_waddr !== 7'd0 || cpri_wdata !== 64'h0
                    || cpri_wlast !== 1'b0 || seq_num !== 16'd0 || iq_tready !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_outputs got=%b/%0d/%h/%b/%0d/%b need=0/0/0/0/0/0",
                             cpri_wen, cpri_waddr, cpri_wdata, cpri_wlast, seq_num, iq_tready);
                end
            end
        join
        checks++;
        if (recv.size() !== 61) begin
            failures++;
            $display("FAIL rstmid_count got=%0d need=61", recv.size());
        end
        for (int i = 0; i < recv.size() && i < exp_q.size(); i++) begin
            checks++;
            if (recv[i].addr !== exp_q[i].addr || recv[i].data !== exp_q[i].data) begin
                failures++;
                $display("FAIL rstmid_word%0d got=%0d/%h need=%0d/%h", i,
                         recv[i].addr, recv[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        clear_sb();
        hdr_info = 64'h5555_AAAA_5555_AAAA;
        push_chunk(16'd0, hdr_info, 64'h5000, 95);
        drive_words(1, 95, 64'h5000);
        wait_drain();
        checks++;
        if (recv.size() !== 99) begin
            failures++;
            $display("FAIL rstmid_next_count got=%0d need=99", recv.size());
        end
        for (int i = 0; i < recv.size() && i < exp_q.size(); i++) begin
            checks++;
            if (recv[i].addr !== exp_q[i].addr || recv[i].data !== exp_q[i].data
                || recv[i].last !== exp_q[i].last) begin
                failures++;
                $display("FAIL rstmid_next_word%0d got=%0d/%h need=%0d/%h", i,
                         recv[i].addr, recv[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_seq_wrap();
        tx_enable = 1'b0;
        repeat (3) @(posedge clk);
        force dut.seq_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_q;
        @(negedge clk);
        checks++;
        if (seq_num !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload got=%h need=ffff", seq_num);
        end
        hdr_info = 64'h7777_0000_7777_0000;
        run_b2b("wrap", 16'hFFFF, 64'h6000);
        checks++;
        if (seq_num !== 16'd2) begin
            failures++;
            $display("FAIL wrap_seq got=%0d need=2", seq_num);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_enable = 1'b0;
        iq_tvalid = 1'b0;
        iq_tdata = 64'h0;
        iq_tlast = 1'b0;
        hdr_info = 64'h0;
        cpri_tready = 1'b1;
        test_reset();
        test_single_chunk();
        test_backpressure();
        test_back_to_back();
        test_len_err();
        test_reset_mid();
        test_seq_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
